// File: rtl/uart_arbitrage_engine.sv
// uart_arbitrage_engine: receives two 16-bit prices over 8N1 UART, compares them
// and transmits a 5-byte HEADER/action/profit/FOOTER result frame.
module uart_arbitrage_engine #(
    parameter int         CLK_FREQ   = 50000000,
    parameter int         BAUD       = 9600,
    parameter logic [7:0] HEADER     = 8'hAA,
    parameter logic [7:0] FOOTER     = 8'h55,
    parameter int         MIN_PROFIT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic uart_rx,
    output logic uart_tx
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam logic [15:0] HALF_M1 = 16'(CPB / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CPB - 1);
    localparam logic [15:0] MIN_P   = 16'(MIN_PROFIT);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
    typedef enum logic [2:0] {HUNT, A_HI, A_LO, B_HI, B_LO, FOOT} parse_state_e;

    logic         sync1_q, sync2_q;
    rx_state_e    rx_state_q, rx_state_d;
    logic [15:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]   rx_bit_q, rx_bit_d;
    logic [7:0]   rx_shift_q, rx_shift_d;
    logic         byte_valid_q, byte_valid_d;
    logic         rx_error_q, rx_error_d;
    parse_state_e parse_q, parse_d;
    logic [15:0]  price_a_q, price_a_d, price_b_q, price_b_d;
    logic         go_q, go_d;
    logic [7:0]   action_q, action_d;
    logic [15:0]  profit_q, profit_d;
    logic         start_q, start_d;
    logic         tx_busy_q, tx_busy_d;
    logic [15:0]  tx_cnt_q, tx_cnt_d;
    logic [3:0]   tx_bit_q, tx_bit_d;
    logic [2:0]   tx_byte_q, tx_byte_d;
    logic [9:0]   tx_shift_q, tx_shift_d;
    logic [31:0]  tx_frame_q, tx_frame_d;
    logic         tx_q, tx_d;
    logic         a_gt;
    logic [15:0]  diff;
    logic         trade;

    assign uart_tx = tx_q;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + 16'd1;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        rx_error_d   = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = 16'd0;
                if (!sync2_q) rx_state_d = R_START;
            end
            R_START: if (rx_cnt_q == HALF_M1) begin
                rx_cnt_d   = 16'd0;
                rx_bit_d   = 3'd0;
                rx_state_d = sync2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt_q == FULL_M1) begin
                rx_cnt_d   = 16'd0;
                rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
            end
            R_STOP: if (rx_cnt_q == FULL_M1) begin
                byte_valid_d = sync2_q;
                rx_error_d   = !sync2_q;
                rx_state_d   = R_IDLE;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    // Received byte stays in rx_shift_q while byte_valid_q is high.
    always_comb begin
        parse_d   = parse_q;
        price_a_d = price_a_q;
        price_b_d = price_b_q;
        go_d      = 1'b0;
        if (rx_error_q) parse_d = HUNT;
        else if (byte_valid_q) begin
            case (parse_q)
                HUNT: if (rx_shift_q == HEADER) parse_d = A_HI;
                A_HI: begin price_a_d = {rx_shift_q, price_a_q[7:0]}; parse_d = A_LO; end
                A_LO: begin price_a_d = {price_a_q[15:8], rx_shift_q}; parse_d = B_HI; end
                B_HI: begin price_b_d = {rx_shift_q, price_b_q[7:0]}; parse_d = B_LO; end
                B_LO: begin price_b_d = {price_b_q[15:8], rx_shift_q}; parse_d = FOOT; end
                FOOT: begin go_d = (rx_shift_q == FOOTER); parse_d = HUNT; end
                default: parse_d = HUNT;
            endcase
        end
    end

    always_comb begin
        a_gt     = price_a_q > price_b_q;
        diff     = a_gt ? price_a_q - price_b_q : price_b_q - price_a_q;
        trade    = diff > MIN_P;
        action_d = go_q ? (trade ? (a_gt ? 8'h01 : 8'h02) : 8'h00) : action_q;
        profit_d = go_q ? (trade ? diff : 16'd0) : profit_q;
        start_d  = go_q;
    end

    // A result arriving while a frame is in flight is dropped.
    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_shift_d = tx_shift_q;
        tx_frame_d = tx_frame_q;
        if (!tx_busy_q) begin
            tx_cnt_d = 16'd0;
            if (start_q) begin
                tx_busy_d  = 1'b1;
                tx_bit_d   = 4'd0;
                tx_byte_d  = 3'd0;
                tx_shift_d = {1'b1, HEADER, 1'b0};
                tx_frame_d = {FOOTER, profit_q[7:0], profit_q[15:8], action_q};
            end
        end else if (tx_cnt_q == FULL_M1) begin
            tx_cnt_d = 16'd0;
            if (tx_bit_q == 4'd9) begin
                if (tx_byte_q == 3'd4) tx_busy_d = 1'b0;
                else begin
                    tx_shift_d = {1'b1, tx_frame_q[7:0], 1'b0};
                    tx_frame_d = {8'h00, tx_frame_q[31:8]};
                    tx_byte_d  = tx_byte_q + 3'd1;
                    tx_bit_d   = 4'd0;
                end
            end else begin
                tx_shift_d = {1'b1, tx_shift_q[9:1]};
                tx_bit_d   = tx_bit_q + 4'd1;
            end
        end
        tx_d = tx_busy_d ? tx_shift_d[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            rx_state_q   <= R_IDLE;
            rx_cnt_q     <= 16'd0;
            rx_bit_q     <= 3'd0;
            rx_shift_q   <= 8'd0;
            byte_valid_q <= 1'b0;
            rx_error_q   <= 1'b0;
            parse_q      <= HUNT;
            price_a_q    <= 16'd0;
            price_b_q    <= 16'd0;
            go_q         <= 1'b0;
            action_q     <= 8'd0;
            profit_q     <= 16'd0;
            start_q      <= 1'b0;
            tx_busy_q    <= 1'b0;
            tx_cnt_q     <= 16'd0;
            tx_bit_q     <= 4'd0;
            tx_byte_q    <= 3'd0;
            tx_shift_q   <= 10'h3FF;
            tx_frame_q   <= 32'd0;
            tx_q         <= 1'b1;
        end else begin
            sync1_q      <= uart_rx;
            sync2_q      <= sync1_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            rx_error_q   <= rx_error_d;
            parse_q      <= parse_d;
            price_a_q    <= price_a_d;
            price_b_q    <= price_b_d;
            go_q         <= go_d;
            action_q     <= action_d;
            profit_q     <= profit_d;
            start_q      <= start_d;
            tx_busy_q    <= tx_busy_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_byte_q    <= tx_byte_d;
            tx_shift_q   <= tx_shift_d;
            tx_frame_q   <= tx_frame_d;
            tx_q         <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_arbitrage_engine.sv
// tb_uart_arbitrage_engine: directed UART frames with hand-computed result frames.
module tb_uart_arbitrage_engine;
    localparam int CPB = 32;
    localparam int STOP_SAMPLE = 3 + CPB / 2 + 9 * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic mon_sel = 1'b0;
    logic tx, tx2, mon_line;
    int checks = 0;
    int failures = 0;
    logic [7:0] rxq[$];
    longint ftq[$];
    longint t_last, hdr_t, lat;

    assign mon_line = mon_sel ? tx2 : tx;

    always #5 clk = ~clk;

    uart_arbitrage_engine #(.CLK_FREQ(3200000), .BAUD(100000)) dut (
        .clk(clk), .rst(rst), .uart_rx(rx), .uart_tx(tx)
    );

    uart_arbitrage_engine #(.CLK_FREQ(3200000), .BAUD(100000), .MIN_PROFIT(50)) dut2 (
        .clk(clk), .rst(rst), .uart_rx(rx), .uart_tx(tx2)
    );

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        t_last = $time;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            rx = b[i];
        end
        repeat (CPB) @(negedge clk);
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] foot);
        send_byte(8'hAA, 1'b1);
        send_byte(a[15:8], 1'b1);
        send_byte(a[7:0], 1'b1);
        send_byte(b[15:8], 1'b1);
        send_byte(b[7:0], 1'b1);
        send_byte(foot, 1'b1);
    endtask

    task automatic expect_frame(input string tag, input logic [39:0] exp);
        int n;
        logic [39:0] got;
        n = 0;
        got = '0;
        while (rxq.size() < 5 && n < 80 * CPB) begin
            @(posedge clk);
            n++;
        end
        if (rxq.size() < 5) check({tag, "_timeout"}, 40'(rxq.size()), 40'd5);
        else begin
            hdr_t = ftq[0];
            for (int i = 0; i < 5; i++) begin
                got = {got[31:0], rxq.pop_front()};
                void'(ftq.pop_front());
            end
            check(tag, got, exp);
        end
    endtask

    task automatic expect_none(input string tag);
        repeat (20 * CPB) @(posedge clk);
        check(tag, 40'(rxq.size()), 40'd0);
        rxq.delete();
        ftq.delete();
    endtask

    task automatic quiet();
        repeat (12 * CPB) @(posedge clk);
        rxq.delete();
        ftq.delete();
    endtask

    initial begin
        logic [7:0] b;
        longint ft;
        forever begin
            @(negedge mon_line);
            ft = $time;
            repeat (CPB / 2) @(posedge clk);
            if (mon_line == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    b[i] = mon_line;
                end
                repeat (CPB) @(posedge clk);
                if (mon_line) begin
                    rxq.push_back(b);
                    ftq.push_back(ft);
                end
            end
        end
    end

    initial begin
        repeat (10) @(posedge clk);
        #1;
        check("reset_tx", 40'(tx), 40'd1);
        check("reset_tx2", 40'(tx2), 40'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4 * CPB) @(negedge clk);

        send_frame(16'd4270, 16'd4235, 8'h55);
        expect_frame("nominal", 40'hAA01002355);
        lat = (hdr_t - t_last + 5) / 10 - STOP_SAMPLE;
        check("latency_le4", 40'(lat >= 0 && lat <= 4), 40'd1);

        send_frame(16'd4235, 16'd4270, 8'h55);
        expect_frame("reverse", 40'hAA02002355);
        send_frame(16'd4270, 16'd4270, 8'h55);
        expect_frame("equal", 40'hAA00000055);
        send_frame(16'hFFFF, 16'h0000, 8'h55);
        expect_frame("extreme", 40'hAA01FFFF55);
        send_frame(16'd100, 16'd101, 8'h55);
        expect_frame("spread_one", 40'hAA02000155);
        quiet();

        send_frame(16'd4270, 16'd4235, 8'h56);
        expect_none("bad_footer");

        send_byte(8'h3C, 1'b1);
        send_byte(8'h12, 1'b1);
        send_frame(16'd4270, 16'd4235, 8'h55);
        expect_frame("garbage_then_valid", 40'hAA01002355);
        expect_none("garbage_single");

        send_byte(8'hAA, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'hAE, 1'b0);
        repeat (20 * CPB) @(negedge clk);
        send_byte(8'h10, 1'b1);
        send_byte(8'h8B, 1'b1);
        send_byte(8'h55, 1'b1);
        expect_none("bad_stop");

        send_byte(8'hAA, 1'b1);
        repeat (4) @(negedge clk);
        rx = 1'b0;
        repeat (8) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        send_byte(8'h10, 1'b1);
        send_byte(8'hAE, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h8B, 1'b1);
        send_byte(8'h55, 1'b1);
        expect_frame("glitch_ignored", 40'hAA01002355);
        quiet();

        send_byte(8'hAA, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'hAE, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_byte(8'h10, 1'b1);
        send_byte(8'h8B, 1'b1);
        send_byte(8'h55, 1'b1);
        expect_none("rst_mid_frame");
        send_frame(16'd4270, 16'd4235, 8'h55);
        expect_frame("after_rst_frame", 40'hAA01002355);
        quiet();

        send_frame(16'd4235, 16'd4270, 8'h55);
        check("tx_start_bit", 40'(tx), 40'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("tx_high_after_rst", 40'(tx), 40'd1);
        @(negedge clk);
        rst = 1'b0;
        quiet();
        check("rst_mid_tx_no_frame", 40'(rxq.size()), 40'd0);
        send_frame(16'd4270, 16'd4235, 8'h55);
        expect_frame("after_rst_tx", 40'hAA01002355);
        quiet();

        mon_sel = 1'b1;
        send_frame(16'd4270, 16'd4235, 8'h55);
        expect_frame("min_profit_below", 40'hAA00000055);
        send_frame(16'd4285, 16'd4235, 8'h55);
        expect_frame("min_profit_equal", 40'hAA00000055);
        send_frame(16'd4170, 16'd4270, 8'h55);
        expect_frame("min_profit_above", 40'hAA02006455);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_arbitrage_engine.md
Name: uart_arbitrage_engine

Overview:
- Receives two 16-bit exchange prices over an 8N1 UART and compares them.
- Decides the trade direction and spread, and transmits a 5-byte result frame on a second UART line.
- Top-level datapath between the host link and the price feed; internally it is a UART RX, a frame parser, a compare/subtract stage and a UART TX.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 9600, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD = 5208.
- HEADER, 8'hAA, start-of-frame byte (RX and TX).
- FOOTER, 8'h55, end-of-frame byte (RX and TX).
- MIN_PROFIT, 0, a spread must be strictly greater than this to report a trade.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- uart_rx  input  1  serial price input; idles high; 8N1, LSB first.
- uart_tx  output  1  serial result output; idles high; 8N1, LSB first.

Behaviour:
- Reset:
  - All state returns to idle on the next clk edge with rst high.
  - uart_tx=1; any partial RX byte, partial frame or TX frame in progress is discarded.
- RX synchronisation: uart_rx passes through a 2-flop synchroniser before use.
- RX byte receiver:
  - IDLE: wait for a falling edge (line low).
  - START: sample at CLKS_PER_BIT/2; if the line is high, treat it as a glitch and return to IDLE.
  - DATA: sample 8 bits, one every CLKS_PER_BIT, at mid-bit, LSB first.
  - STOP: sample at mid-bit. If high, pulse byte_valid for 1 clk with the data; if low (framing error), pulse rx_error instead.
  - Return to IDLE after STOP.
- Frame parser states are HUNT, A_HI, A_LO, B_HI, B_LO, FOOT.
  - HUNT: a byte equal to HEADER goes to A_HI; any other byte stays in HUNT.
  - A_HI/A_LO/B_HI/B_LO: store bytes big-endian; price_a = {A_HI, A_LO}, price_b = {B_HI, B_LO}; both unsigned, in cents.
  - FOOT: a byte equal to FOOTER marks the frame valid and raises the compute strobe; any other byte discards the frame. Both return to HUNT.
  - rx_error in any state discards the frame and returns to HUNT.
- Compute (registered, 1 clk after the footer is accepted):
  - If price_a > price_b: profit = price_a - price_b, action = 8'h01 (buy on B, sell on A).
  - If price_b > price_a: profit = price_b - price_a, action = 8'h02 (buy on A, sell on B).
  - If profit <= MIN_PROFIT, or the prices are equal: action = 8'h00 and profit = 0.
  - profit is 16-bit unsigned and cannot overflow.
- TX frame: five bytes HEADER, action, profit[15:8], profit[7:0], FOOTER.
  - Each byte is sent as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit CLKS_PER_BIT clocks long.
  - Bytes are back-to-back with no idle gap.
- Latency: the start bit of the TX header begins no more than 4 clk after the footer's stop-bit sample.
- Overlap:
  - RX and parsing continue while TX is busy.
  - A result completed while TX is busy is dropped; there is no queue.
  - One result is sent per valid frame when TX is idle.
- A HEADER value appearing inside the price fields is treated as data; there is no resynchronisation mid-frame.

Test Plan:
- Nominal trade:
  - Stimulus: rst high for 10 clk, then send AA 10 AE 10 8B 55 (A=4270, B=4235).
  - Required: uart_tx emits AA 01 00 23 55 (profit 35), with the TX start bit within 4 clk after the footer stop sample.
- Reverse direction: AA 10 8B 10 AE 55 -> AA 02 00 23 55.
- Equal prices: AA 10 AE 10 AE 55 -> AA 00 00 00 55.
- Bad framing:
  - Bad footer: AA 10 AE 10 8B 56 -> no TX activity.
  - Garbage first: 3C 12 then a valid frame -> exactly one response, for the valid frame.
  - A stop bit forced low on the A_LO byte -> frame discarded, no TX.
- Glitch and reset:
  - A 1 µs low pulse on uart_rx -> no byte is received.
  - Assert rst mid-frame and mid-TX -> uart_tx goes high on the next clk; a following full frame is processed normally.
- Extremes: A=0xFFFF, B=0x0000 -> AA 01 FF FF 55. With MIN_PROFIT=50, A=4270 and B=4235 -> AA 00 00 00 55.
